key_pulse_conditioner: RTL and testbench
========================================

// Module: key_pulse_conditioner
// PURPOSE
//   Front-end stage between the raw DE1-SoC pushbuttons/switches and the control block.
//   Synchronises the keys, debounces them and emits clean one-cycle press pulses.
//   Pulses are used as step/start/clear events. On a start press, the SW operand is
//   captured so the datapath sees a stable X.
//   Outputs feed the control block (start, reset, step) and the datapath X input directly.
// PARAMETERS
//   N_KEYS          4       number of pushbuttons conditioned
//   X_W             4       width of switch operand captured
//   DEBOUNCE_CYCLES 500000  stable cycles required to accept a level change (10 ms @ 50 MHz)
//   CNT_W           20      debounce/repeat counter width; must hold DEBOUNCE_CYCLES-1
//   START_KEY       1       key index whose press captures sw into x_latched
//   CLEAR_KEY       2       key index whose press clears x_valid
//   REPEAT_DELAY    25000000 cycles held before first auto-repeat (AUTO_REPEAT_EN only)
//   REPEAT_PERIOD   5000000 cycles between subsequent repeats (AUTO_REPEAT_EN only)
// PORTS
//   clock      in   1       system clock (CLOCK_50)
//   reset      in   1       synchronous, active-high reset
//   key_n      in   N_KEYS  raw pushbuttons, active-low, asynchronous
//   sw         in   X_W     raw slide switches, asynchronous
//   press      out  N_KEYS  one-cycle pulse per accepted press, per key
//   level      out  N_KEYS  debounced pressed level (1 = held)
//   x_latched  out  X_W     switch value captured on press[START_KEY]
//   x_valid    out  1       x_latched holds a captured value
// BEHAVIOUR
//   - Reset (sync, active-high): sync flops hold 0 (released); states = IDLE.
//     Counters = 0. press = 0, level = 0, x_latched = 0, x_valid = 0.
//     Reset wins over every other event in the same cycle.
//   - Synchronisation:
//     - ~key_n passes through a 2-flop synchroniser per key.
//     - sw passes through a 2-flop synchroniser per bit.
//   - Per-key FSM (independent per key):
//     - IDLE -> PRESS_WAIT when the synced key = 1.
//     - PRESS_WAIT:
//       - Counts while synced = 1; synced = 0 -> IDLE, count cleared.
//       - Count = DEBOUNCE_CYCLES-1 -> HELD.
//     - HELD: level = 1. Synced = 0 -> RELEASE_WAIT, count cleared.
//     - RELEASE_WAIT:
//       - Counts while synced = 0; synced = 1 -> HELD, no new press.
//       - Count = DEBOUNCE_CYCLES-1 -> IDLE, level = 0.
//   - press[i] is registered and high for exactly the first cycle the state is HELD.
//     A HELD->RELEASE_WAIT->HELD bounce never re-pulses.
//   - Latency:
//     - press[i] rises DEBOUNCE_CYCLES+3 rising edges after key_n[i] falls and stays low.
//     - level[i] falls DEBOUNCE_CYCLES+3 edges after a stable release.
//   - Glitches (either polarity) shorter than DEBOUNCE_CYCLES are fully rejected.
//   - Simultaneous presses on several keys produce simultaneous pulses; no priority.
//   - Operand capture:
//     - On the same edge press[START_KEY] rises, x_latched <= synced sw and x_valid <= 1.
//     - press[CLEAR_KEY] sets x_valid <= 0; x_latched is retained.
//     - If both pulse together, capture wins (x_valid = 1).
//   - Key held through reset deassertion: FSM starts in IDLE, so a press is emitted
//     after the normal debounce.
//   - Reset asserted mid-debounce aborts the count; no pulse is emitted.
//   - Counters saturate/clear per state; no wrap-around is possible.
// CONFIGURATION
//   AUTO_REPEAT_EN defined:
//     - While HELD, a per-key repeat counter runs.
//     - Extra press pulses fire REPEAT_DELAY cycles after entering HELD, then every
//       REPEAT_PERIOD cycles.
//     - Leaving HELD (including to RELEASE_WAIT) resets the repeat counter.
//     - Repeats on START_KEY also re-capture sw.
//   AUTO_REPEAT_EN undefined:
//     - Exactly one pulse per accepted press; repeat logic and parameters are unused.
// TESTING (bench: DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6)
//   1. Reset 2 cycles, key_n=4'hF -> press=0, level=0, x_latched=0, x_valid=0.
//   2. key_n[0] low and stable -> press[0] one pulse exactly 11 edges later; level[0]=1.
//   3. key_n[0] low 5 cycles then high; repeat 3 times -> no pulse, level[0] stays 0.
//   4. sw=4'hA, press KEY1 -> x_latched=4'hA, x_valid=1 on the pulse edge.
//      Then press KEY2 -> x_valid=0, x_latched=4'hA.
//   5. Held key bounces high for 3 cycles -> no second pulse; stable release 8+ cycles
//      -> level=0.
//   6. reset asserted at debounce count 5 -> no pulse; with AUTO_REPEAT_EN, a 40-cycle
//      hold -> pulses at entry, +20, +26, +32, +38.

Source files
------------

// File: rtl/key_pulse_conditioner.sv
// Pushbutton/switch front end: 2-flop sync, per-key debounce FSM, one-cycle press pulses,
// and start-key operand capture. Define AUTO_REPEAT_EN to add held-key auto-repeat pulses.
//
//   state        | meaning
//   IDLE         | key released and accepted as released
//   PRESS_WAIT   | synced key pressed, counting stable-press cycles
//   HELD         | press accepted, level = 1
//   RELEASE_WAIT | synced key released, counting stable-release cycles, level still 1
module key_pulse_conditioner #(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned X_W             = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned START_KEY       = 1,
  parameter int unsigned CLEAR_KEY       = 2,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [X_W-1:0]    sw,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] level,
  output logic [X_W-1:0]    x_latched,
  output logic              x_valid
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time sanity checks on the configuration.
  if (CNT_W < $clog2(DEBOUNCE_CYCLES)) begin : g_cnt_w_check
    $error("CNT_W too narrow for DEBOUNCE_CYCLES-1");
  end
  if (START_KEY >= N_KEYS || CLEAR_KEY >= N_KEYS) begin : g_key_idx_check
    $error("START_KEY/CLEAR_KEY out of range");
  end
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_repeat_check
    $error("REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
  end

  logic [N_KEYS-1:0] key_meta_q, key_sync_q;
  logic [X_W-1:0]    sw_meta_q, sw_sync_q;
  key_state_e        state_q [N_KEYS];
  key_state_e        state_d [N_KEYS];
  logic [CNT_W-1:0]  cnt_q [N_KEYS];
  logic [CNT_W-1:0]  cnt_d [N_KEYS];
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] level_q, level_d;
  logic [X_W-1:0]    x_latched_q, x_latched_d;
  logic              x_valid_q, x_valid_d;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0]  rpt_q [N_KEYS];
  logic [RPT_W-1:0]  rpt_d [N_KEYS];
`endif

  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      press_d[i] = 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt_d[i]   = rpt_q[i];
`endif
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (key_sync_q[i]) state_d[i] = PRESS_WAIT;
        end
        PRESS_WAIT: begin
          // A drop in the synced key takes priority over the terminal count.
          if (!key_sync_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
`ifdef AUTO_REPEAT_EN
            rpt_d[i]   = RPT_FIRST;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        HELD: begin
          cnt_d[i] = '0;
          if (!key_sync_q[i]) begin
            state_d[i] = RELEASE_WAIT;
`ifdef AUTO_REPEAT_EN
            rpt_d[i]   = '0;
`endif
          end
`ifdef AUTO_REPEAT_EN
          else if (rpt_q[i] == '0) begin
            press_d[i] = 1'b1;
            rpt_d[i]   = RPT_NEXT;
          end else begin
            rpt_d[i] = rpt_q[i] - 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          if (key_sync_q[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
`ifdef AUTO_REPEAT_EN
            rpt_d[i]   = RPT_FIRST;
`endif
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      level_d[i] = (state_d[i] == HELD) || (state_d[i] == RELEASE_WAIT);
    end

    // Capture is applied last so it wins over a simultaneous clear.
    x_latched_d = x_latched_q;
    x_valid_d   = x_valid_q;
    if (press_d[CLEAR_KEY]) x_valid_d = 1'b0;
    if (press_d[START_KEY]) begin
      x_latched_d = sw_sync_q;
      x_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_meta_q  <= '0;
      key_sync_q  <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      press_q     <= '0;
      level_q     <= '0;
      x_latched_q <= '0;
      x_valid_q   <= 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
`ifdef AUTO_REPEAT_EN
        rpt_q[i]   <= '0;
`endif
      end
    end else begin
      key_meta_q  <= ~key_n;
      key_sync_q  <= key_meta_q;
      sw_meta_q   <= sw;
      sw_sync_q   <= sw_meta_q;
      press_q     <= press_d;
      level_q     <= level_d;
      x_latched_q <= x_latched_d;
      x_valid_q   <= x_valid_d;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef AUTO_REPEAT_EN
        rpt_q[i]   <= rpt_d[i];
`endif
      end
    end
  end

  assign press     = press_q;
  assign level     = level_q;
  assign x_latched = x_latched_q;
  assign x_valid   = x_valid_q;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Bench for key_pulse_conditioner: run-length debounce model checked every cycle,
// plus directed literal checks on pulse timing, capture/clear and reset behaviour.
module tb_key_pulse_conditioner;
  localparam int NK = 4;
  localparam int XW = 4;
  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RP = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NK-1:0] key_n = 4'hF;
  logic [XW-1:0] sw = '0;
  logic [NK-1:0] press, level;
  logic [XW-1:0] x_latched;
  logic x_valid;

  key_pulse_conditioner #(
    .N_KEYS(NK), .X_W(XW), .DEBOUNCE_CYCLES(DB), .CNT_W(4),
    .START_KEY(1), .CLEAR_KEY(2), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset(reset), .key_n(key_n), .sw(sw),
    .press(press), .level(level), .x_latched(x_latched), .x_valid(x_valid)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;
  bit cmp_en = 1'b0;
  int n_press [NK];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: a key's accepted level flips once the synced input has disagreed with it
  // for DB+1 consecutive samples; "held" means accepted pressed and currently agreeing.
  logic [NK-1:0] m_k1 = '0, m_k2 = '0, m_level = '0, m_press = '0;
  logic [XW-1:0] m_sw1 = '0, m_sw2 = '0, m_x = '0;
  logic m_xv = 1'b0;
  int run [NK];
  int age [NK];

  always @(posedge clock) begin : model
    logic [NK-1:0] s;
    logic [XW-1:0] swv;
    bit was_held, now_held;
    if (reset) begin
      m_k1 = '0; m_k2 = '0; m_sw1 = '0; m_sw2 = '0;
      m_level = '0; m_press = '0; m_x = '0; m_xv = 1'b0;
      for (int i = 0; i < NK; i++) begin run[i] = 0; age[i] = 0; end
    end else begin
      s = m_k2; swv = m_sw2;
      m_k2 = m_k1; m_k1 = ~key_n;
      m_sw2 = m_sw1; m_sw1 = sw;
      m_press = '0;
      for (int i = 0; i < NK; i++) begin
        was_held = m_level[i] && (run[i] == 0);
        if (s[i] == m_level[i]) run[i] = 0;
        else run[i] = run[i] + 1;
        if (run[i] == DB + 1) begin
          run[i] = 0;
          m_level[i] = s[i];
          if (s[i]) m_press[i] = 1'b1;
        end
        now_held = m_level[i] && (run[i] == 0);
        if (now_held) age[i] = was_held ? age[i] + 1 : 0;
`ifdef AUTO_REPEAT_EN
        if (now_held && was_held && (age[i] == RD || (age[i] > RD && (age[i] - RD) % RP == 0)))
          m_press[i] = 1'b1;
`endif
      end
      if (m_press[2]) m_xv = 1'b0;
      if (m_press[1]) begin m_x = swv; m_xv = 1'b1; end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("press", press, m_press);
      check("level", level, m_level);
      check("x_latched", x_latched, m_x);
      check("x_valid", x_valid, m_xv);
      for (int i = 0; i < NK; i++) if (press[i]) n_press[i]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  int snap;

  initial begin
    for (int i = 0; i < NK; i++) n_press[i] = 0;
    // 1: reset
    repeat (2) @(posedge clock);
    #1;
    check("rst_press", press, 4'h0);
    check("rst_level", level, 4'h0);
    check("rst_x", x_latched, 4'h0);
    check("rst_xv", x_valid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    cmp_en = 1'b1;
    tick(3);

    // 2: stable press on key 0, pulse exactly 11 edges later
    key_n[0] = 1'b0;
    edges(10);
    check("t2_early", press[0], 1'b0);
    edges(1);
    check("t2_pulse", press, 4'b0001);
    check("t2_model", m_press, 4'b0001);
    check("t2_level", level[0], 1'b1);
    edges(1);
    check("t2_once", press[0], 1'b0);
    @(negedge clock);
    key_n[0] = 1'b1;
    edges(10);
    check("t2_lvl_hold", level[0], 1'b1);
    edges(1);
    check("t2_lvl_fall", level[0], 1'b0);
    tick(3);

    // 3: short glitches rejected
    snap = n_press[0];
    for (int r = 0; r < 3; r++) begin
      key_n[0] = 1'b0; tick(5);
      key_n[0] = 1'b1; tick(5);
    end
    tick(6);
    check("t3_nopulse", n_press[0] - snap, 0);
    check("t3_level", level[0], 1'b0);

    // 4: capture on start key, clear on clear key
    sw = 4'hA;
    key_n[1] = 1'b0;
    edges(10);
    check("t4_xv_before", x_valid, 1'b0);
    edges(1);
    check("t4_press", press, 4'b0010);
    check("t4_x", x_latched, 4'hA);
    check("t4_xv", x_valid, 1'b1);
    @(negedge clock);
    tick(2);
    key_n[1] = 1'b1;
    sw = 4'h5;
    tick(14);
    key_n[2] = 1'b0;
    edges(11);
    check("t4_clr_press", press, 4'b0100);
    check("t4_clr_xv", x_valid, 1'b0);
    check("t4_clr_x", x_latched, 4'hA);
    @(negedge clock);
    tick(2);
    key_n[2] = 1'b1;
    tick(14);

    // simultaneous start+clear: capture wins
    sw = 4'h3;
    key_n = 4'b1001;
    edges(11);
    check("both_press", press, 4'b0110);
    check("both_xv", x_valid, 1'b1);
    check("both_x", x_latched, 4'h3);
    @(negedge clock);
    key_n = 4'hF;
    tick(14);

    // 5: bounce while held, then stable release
    key_n[3] = 1'b0;
    tick(14);
    snap = n_press[3];
    key_n[3] = 1'b1; tick(3);
    key_n[3] = 1'b0; tick(5);
    key_n[3] = 1'b1; tick(6);
    check("t5_still_lvl", level[3], 1'b1);
    tick(8);
    check("t5_released", level[3], 1'b0);
    check("t5_no_repulse", n_press[3] - snap, 0);

    // 6a: reset at debounce count 5 aborts
    snap = n_press[0];
    key_n[0] = 1'b0;
    tick(8);
    reset = 1'b1;
    key_n[0] = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(15);
    check("t6_abort", n_press[0] - snap, 0);
    check("t6_abort_lvl", level[0], 1'b0);

    // key held through reset deassertion: normal debounce afterwards
    key_n[0] = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    edges(10);
    check("t6_thru_early", press[0], 1'b0);
    edges(1);
    check("t6_thru_pulse", press[0], 1'b1);
    @(negedge clock);
    key_n[0] = 1'b1;
    tick(14);

    // 6b: long hold
    snap = n_press[0];
    key_n[0] = 1'b0;
    tick(51);
    key_n[0] = 1'b1;
    tick(16);
`ifdef AUTO_REPEAT_EN
    check("t6_hold_pulses", n_press[0] - snap, 5);
`else
    check("t6_hold_pulses", n_press[0] - snap, 1);
`endif
    check("t6_hold_lvl", level[0], 1'b0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
